// File: rtl/spi_gpio_pkg.sv
// Shared definitions for the SPI GPIO expander: register addresses, command
// byte field positions, the soft-reset key and the frame FSM state type.
package spi_gpio_pkg;

    // Register addresses (command bits [6:4]); 6 and 7 are reserved.
    localparam logic [2:0] REG_OUT      = 3'd0;
    localparam logic [2:0] REG_DIR      = 3'd1;
    localparam logic [2:0] REG_IN       = 3'd2;
    localparam logic [2:0] REG_IRQ_EN   = 3'd3;
    localparam logic [2:0] REG_IRQ_STAT = 3'd4;
    localparam logic [2:0] REG_SOFT_RST = 3'd5;

    // Command byte layout: [7] write, [6:4] register, [3] reserved, [2:0] bank.
    localparam int unsigned CMD_WR_BIT   = 7;
    localparam int unsigned CMD_REG_LSB  = 4;
    localparam int unsigned CMD_RSVD_BIT = 3;
    localparam int unsigned CMD_BANK_LSB = 0;

    localparam logic [7:0] SOFT_RST_KEY = 8'hA5;

    typedef enum logic {
        EXP_CMD  = 1'b0,
        EXP_DATA = 1'b1
    } exp_state_t;

endpackage

// File: rtl/spi_gpio_expander_if.sv
// SPI bus bundle for the GPIO expander.
//   ss   : select, active-high (frame open while 1)
//   sclk : SPI clock, mode 0
//   mosi : data towards the expander, MSB first
//   miso : data from the expander, MSB first
interface spi_gpio_expander_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output ss, output sclk, output mosi, input miso);
    modport slave  (input ss, input sclk, input mosi, output miso);
endinterface

// File: rtl/spi_byte_slave.sv
// Mode-0 SPI byte slave running in the clk domain.
//   clk, rst       : system clock, synchronous active-high reset
//   ss, sclk, mosi : raw asynchronous SPI inputs
//   tx_byte        : byte loaded into the miso shifter on the ss-rise pulse
//   miso           : MSB of the transmit shifter, 0 while ss is low
//   byte_done      : one-cycle pulse on the 8th sampled sclk rise of a frame
//   rx_byte        : received byte, valid while byte_done is high
module spi_byte_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_d;
    logic                   sclk_d;
    logic                   ss_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   ss_rise;
    logic                   ss_fall;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [6:0]             rx_q;
    logic [7:0]             tx_q;
    logic [3:0]             bit_cnt;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // The 8th bit is taken straight from the synchroniser so the byte is
    // complete in the same cycle as the sclk-rise pulse that carries it.
    assign byte_done = ss_s & ~ss_rise & sclk_rise & (bit_cnt == 4'd7);
    assign rx_byte   = {rx_q, mosi_s};
    assign miso      = ss_s & tx_q[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_d      <= 1'b0;
            sclk_d    <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_d      <= ss_s;
            sclk_d    <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q    <= '0;
            tx_q    <= '0;
            bit_cnt <= '0;
        end else if (ss_rise) begin
            rx_q    <= '0;
            tx_q    <= tx_byte;
            bit_cnt <= '0;
        end else if (ss_fall) begin
            tx_q <= '0;
        end else if (ss_s) begin
            // Counter saturates at 8 so trailing bits are ignored.
            if (sclk_rise && bit_cnt != 4'd8) begin
                rx_q    <= {rx_q[5:0], mosi_s};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (sclk_fall) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/spi_gpio_expander.sv
// SPI-controlled GPIO expander: command/data frame FSM, per-bank register
// file (OUT, DIR, IN, IRQ_EN, IRQ_STAT, SOFT_RST) and edge interrupts.
//   clk, rst : system clock, synchronous active-high reset
//   spi      : SPI slave bus (ss, sclk, mosi in; miso out)
//   gpio_in  : asynchronous pin levels
//   gpio_out : OUT register
//   gpio_oe  : DIR register, 1 = drive
//   irq      : registered OR of IRQ_STAT
module spi_gpio_expander
    import spi_gpio_pkg::*;
#(
    parameter int unsigned NUM_GPIO    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_gpio_expander_if.slave  spi,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oe,
    output logic                irq
);

    localparam int unsigned NUM_BANKS = NUM_GPIO / 8;

    exp_state_t          state_q;
    exp_state_t          state_d;
    logic [7:0]          cmd_q;
    logic [NUM_GPIO-1:0] out_q;
    logic [NUM_GPIO-1:0] dir_q;
    logic [NUM_GPIO-1:0] ien_q;
    logic [NUM_GPIO-1:0] ist_q;
    logic                irq_q;
    logic [NUM_GPIO-1:0] in_sync [SYNC_STAGES];
    logic [NUM_GPIO-1:0] in_d;
    logic [NUM_GPIO-1:0] in_s;
    logic [NUM_GPIO-1:0] in_edge;

    logic                byte_done;
    logic [7:0]          rx_byte;
    logic [7:0]          tx_byte;

    logic                cmd_wr;
    logic [2:0]          cmd_reg;
    logic [2:0]          cmd_bank;
    logic                unused_cmd_rsvd;
    logic                bank_ok;
    logic [NUM_GPIO-1:0] lane_mask;
    logic [NUM_GPIO-1:0] wr_data;
    logic [7:0]          rd_byte;
    logic                exec_wr;
    logic                wr_out;
    logic                wr_dir;
    logic                wr_ien;
    logic                wr_ist;
    logic                soft_rst;

    spi_byte_slave #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .ss        (spi.ss),
        .sclk      (spi.sclk),
        .mosi      (spi.mosi),
        .tx_byte   (tx_byte),
        .miso      (spi.miso),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    assign cmd_wr          = cmd_q[CMD_WR_BIT];
    assign cmd_reg         = cmd_q[CMD_REG_LSB +: 3];
    assign cmd_bank        = cmd_q[CMD_BANK_LSB +: 3];
    assign unused_cmd_rsvd = cmd_q[CMD_RSVD_BIT];

    assign in_s    = in_sync[SYNC_STAGES-1];
    assign in_edge = in_s ^ in_d;
    assign wr_data = {NUM_BANKS{rx_byte}};

    // Bank decode: a bank outside the configured pin count matches no lane,
    // which makes it read as 0x00 and ignore writes.
    always_comb begin
        bank_ok   = 1'b0;
        lane_mask = '0;
        rd_byte   = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (cmd_bank == 3'(b)) begin
                bank_ok              = 1'b1;
                lane_mask[b*8 +: 8]  = '1;
                case (cmd_reg)
                    REG_OUT:      rd_byte = out_q[b*8 +: 8];
                    REG_DIR:      rd_byte = dir_q[b*8 +: 8];
                    REG_IN:       rd_byte = in_s[b*8 +: 8];
                    REG_IRQ_EN:   rd_byte = ien_q[b*8 +: 8];
                    REG_IRQ_STAT: rd_byte = ist_q[b*8 +: 8];
                    default:      rd_byte = '0;
                endcase
            end
        end
    end

    always_comb begin
        exec_wr  = byte_done && (state_q == EXP_DATA) && cmd_wr && bank_ok;
        wr_out   = exec_wr && (cmd_reg == REG_OUT);
        wr_dir   = exec_wr && (cmd_reg == REG_DIR);
        wr_ien   = exec_wr && (cmd_reg == REG_IRQ_EN);
        wr_ist   = exec_wr && (cmd_reg == REG_IRQ_STAT);
        soft_rst = exec_wr && (cmd_reg == REG_SOFT_RST) && (rx_byte == SOFT_RST_KEY);
        tx_byte  = ((state_q == EXP_DATA) && !cmd_wr) ? rd_byte : '0;
    end

    always_comb begin
        state_d = state_q;
        if (byte_done) begin
            case (state_q)
                EXP_CMD:  state_d = EXP_DATA;
                EXP_DATA: state_d = EXP_CMD;
                default:  state_d = EXP_CMD;
            endcase
        end
    end

    // Pin synchronisers are not cleared by SOFT_RST so IN keeps tracking pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                in_sync[i] <= '0;
            end
            in_d <= '0;
        end else begin
            in_sync[0] <= gpio_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                in_sync[i] <= in_sync[i-1];
            end
            in_d <= in_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            state_q <= EXP_CMD;
            cmd_q   <= '0;
            out_q   <= '0;
            dir_q   <= '0;
            ien_q   <= '0;
            ist_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (byte_done && (state_q == EXP_CMD)) begin
                cmd_q <= rx_byte;
            end
            if (wr_out) begin
                out_q <= (out_q & ~lane_mask) | (wr_data & lane_mask);
            end
            if (wr_dir) begin
                dir_q <= (dir_q & ~lane_mask) | (wr_data & lane_mask);
            end
            if (wr_ien) begin
                ien_q <= (ien_q & ~lane_mask) | (wr_data & lane_mask);
            end
            // New edges are OR-ed in after the clear so a set wins.
            ist_q <= (ist_q & ~(wr_ist ? (wr_data & lane_mask) : '0))
                   | (in_edge & ien_q);
            irq_q <= |ist_q;
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;

endmodule

// File: doc/spi_gpio_expander.md
SPI_GPIO_EXPANDER -- requirements
Module: spi_gpio_expander

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 16, pin count; multiple of 8, range 8..64.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on ss/sclk/mosi/gpio_in; minimum 2.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ss  input  1  SPI select, active-high (frame open while 1).
REQ-006 SHALL have port sclk  input  1  SPI clock, mode 0 (idle low).
REQ-007 SHALL have port mosi  input  1  SPI data in, MSB first.
REQ-008 SHALL have port miso  output  1  SPI data out, MSB first; 0 while ss low.
REQ-009 SHALL have port gpio_in  input  NUM_GPIO  pin input levels, asynchronous.
REQ-010 SHALL have port gpio_out  output  NUM_GPIO  pin output levels (OUT register).
REQ-011 SHALL have port gpio_oe  output  NUM_GPIO  pin output enables (DIR register, 1 = drive).
REQ-012 SHALL have port irq  output  1  level interrupt, OR of IRQ_STAT.

Function
REQ-013 SHALL pass ss, sclk, mosi through SYNC_STAGES flops, then detect sclk rise/fall and ss rise/fall as one-cycle pulses; sclk frequency limit clk/4.
REQ-014 SHALL carry one byte per ss-high window: sample mosi on sclk rise, shift miso on sclk fall; bits after the 8th ignored.
REQ-015 SHALL hold a frame FSM EXP_CMD / EXP_DATA; a complete byte in EXP_CMD latches the command and moves to EXP_DATA; a complete byte in EXP_DATA executes and returns to EXP_CMD.
REQ-016 SHALL discard a frame closed by ss fall with fewer than 8 bits, leaving FSM state unchanged.
REQ-017 Command byte SHALL decode: bit7 1=write/0=read, bits[6:4] register, bit3 reserved (ignored), bits[2:0] bank (byte lane of NUM_GPIO).
REQ-018 Registers (per 8-bit bank) SHALL be: 0 OUT rw, 1 DIR rw, 2 IN ro, 3 IRQ_EN rw, 4 IRQ_STAT write-1-to-clear, 5 SOFT_RST wo, 6-7 reserved read 0x00.
REQ-019 Bank >= NUM_GPIO/8 SHALL ignore writes and read 0x00; writes to IN or reserved registers SHALL be ignored.
REQ-020 Write SHALL update the register in the clk cycle after the 8th sampled sclk rise of the data frame; gpio_out/gpio_oe reflect it that same cycle (registered outputs).
REQ-021 Read SHALL load the addressed bank value into the shift register on the ss-rise pulse of the data frame, so bit7 is on miso before the first sclk rise.
REQ-022 IN SHALL be gpio_in after SYNC_STAGES flops, regardless of DIR.
REQ-023 Any edge on a synchronised input bit with IRQ_EN=1 SHALL set its IRQ_STAT bit the next cycle; set in the same cycle as a W1C clear wins.
REQ-024 irq SHALL be registered, asserted the cycle after any IRQ_STAT bit is 1.
REQ-025 Writing 0xA5 to SOFT_RST (any valid bank) SHALL return all registers and FSM to reset values; other values ignored.
REQ-026 ss fall mid-data-frame SHALL not execute the command; FSM stays EXP_DATA with command retained.

Reset
REQ-027 rst SHALL clear OUT, DIR, IRQ_EN, IRQ_STAT, shift register, bit counter, command latch, synchronisers; FSM to EXP_CMD.
REQ-028 During and after rst: gpio_out=0, gpio_oe=0, miso=0, irq=0; rst mid-frame aborts the frame with no register write.

Structure
REQ-029 Shared package spi_gpio_pkg SHALL hold register address constants, command bit positions, SOFT_RST key 0xA5, FSM state enum.
REQ-030 Sub-module spi_byte_slave SHALL contain synchronisers, edge detect, bit counter, shift register; top holds FSM, register file, IRQ logic.

Verification
REQ-031 NUM_GPIO=16: write DIR bank0=0xFF, OUT bank0=0xAA -> gpio_oe=0x00FF, gpio_out=0x00AA.
REQ-032 gpio_in=0x5A3C, read IN bank1 (cmd 0x21) -> miso returns 0x5A.
REQ-033 IRQ_EN bank0=0x01, toggle gpio_in[0] -> irq=1; write IRQ_STAT bank0=0x01 -> irq=0.
REQ-034 5-bit frame then full cmd 0x80 + data 0x33 -> OUT bank0=0x33, short frame ignored.
REQ-035 Write OUT bank 2 (cmd 0x82, 0xFF) with NUM_GPIO=16 -> no change; read bank 2 -> 0x00.
REQ-036 rst asserted after 4 data bits of OUT write -> OUT=0, next full cmd/data pair executes normally.
